// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry reverse-registered valid/ready skid buffer
// Optional feature macro: SKID_STALL_CNT_EN (adds stall_cnt port and 32-bit saturating stall counter)

module skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] m_data,
  output logic          valid_o,
  input  logic          ready_i
`ifdef SKID_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  // Occupancy: EMPTY = nothing held, BUSY = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] sk_q, sk_d;

  logic in_hs;
  logic out_hs;

  // ready_o comes straight from a flop so downstream ready never reaches upstream combinationally.
  assign ready_o = ready_q;
  assign valid_o = (state_q != EMPTY);
  assign m_data  = main_q;

  assign in_hs  = valid_i & ready_q;
  assign out_hs = valid_o & ready_i;

  // Next-state and datapath steering; ready for next cycle follows the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    sk_d    = sk_q;
    ready_d = ready_q;
    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          main_d  = s_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_hs && out_hs) begin
          main_d = s_data;
        end else if (in_hs) begin
          // Downstream stalled while a beat was in flight: park it in skid.
          sk_d    = s_data;
          state_d = FULL;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so no new beat can arrive.
        if (out_hs) begin
          main_d  = sk_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    ready_d = (state_d != FULL);
  end

  // State, ready and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      sk_q    <= sk_d;
    end
  end

`ifdef SKID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt = stall_cnt_q;

  // Count cycles where a beat is presented but refused; saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule
